// File: rtl/store_unit_pkg.sv
// Shared CPU definitions for the load/store path: opcodes, width codes,
// stage encodings and the store FSM state type.
package store_unit_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] STAGE_EX  = 2'd2;
    localparam logic [1:0] STAGE_MEM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WRITE = 2'd2,
        ST_HOLD  = 2'd3
    } store_state_t;

endpackage

// File: rtl/store_unit_if.sv
// CPU-side instruction fields in, data-memory write port out.
interface store_unit_if
    import store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic [1:0]            stage;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [31:0]           bus_rs1;
    logic [31:0]           bus_rs2;
    logic [31:0]           immediate;
    logic                  dmem_write_enable;
    logic                  dmem_read_enable;
    logic [ADDR_WIDTH-1:0] dmem_address;
    logic [31:0]           dmem_write_data;
    logic [3:0]            dmem_byte_enable;
    logic                  store_done;
    logic                  store_fault;

    // CPU / bench side
    modport master (
        output stage, opcode, funct3, bus_rs1, bus_rs2, immediate,
        input  dmem_write_enable, dmem_read_enable, dmem_address,
               dmem_write_data, dmem_byte_enable, store_done, store_fault
    );

    // Store unit side
    modport slave (
        input  stage, opcode, funct3, bus_rs1, bus_rs2, immediate,
        output dmem_write_enable, dmem_read_enable, dmem_address,
               dmem_write_data, dmem_byte_enable, store_done, store_fault
    );

endinterface

// File: rtl/store_unit_lane_align.sv
// Combinational lane aligner: places store data into its byte lanes and
// reports whether the width/offset pair is a legal access.
module store_lane_align
    import store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rs2,
    output logic [3:0]  byte_enable,
    output logic [31:0] data,
    output logic        legal
);

    // Width decode: replicate the low bytes across the word so the mask alone
    // selects the destination lanes.
    always_comb begin
        byte_enable = 4'b0000;
        data        = rs2;
        legal       = 1'b0;
        case (funct3)
            F3_SB: begin
                legal       = 1'b1;
                byte_enable = 4'b0001 << offset;
                data        = {4{rs2[7:0]}};
            end
            F3_SH: begin
                legal       = ~offset[0];
                byte_enable = 4'b0011 << offset;
                data        = {2{rs2[15:0]}};
            end
            F3_SW: begin
                legal       = (offset == 2'b00);
                byte_enable = 4'b1111;
                data        = rs2;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// RV32I store unit: latches rs1+imm, rs2 and width in the execute stage and
// issues a single byte-enabled data-memory write in the memory stage.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int         ADDR_WIDTH   = 32,
    parameter logic [6:0] STORE_OPCODE = OPC_STORE
)(
    input  logic         clk,
    input  logic         rst_n,
    store_unit_if.slave  bus
);

    store_state_t          state;

    logic signed [31:0]    ea_sum_p0;
    logic signed [31:0]    ea_p1;
    logic [31:0]           rs2_p1;
    logic [2:0]            funct3_p1;

    logic [3:0]            lane_be_p1;
    logic [31:0]           lane_data_p1;
    logic                  legal_p1;

    logic                  we_p2;
    logic                  done_p2;
    logic                  fault_p2;
    logic [ADDR_WIDTH-1:0] addr_p2;
    logic [31:0]           data_p2;
    logic [3:0]            be_p2;

    logic                  capture_p0;

    // Effective address with 32-bit wrap-around.
    assign ea_sum_p0  = signed'(bus.bus_rs1) + signed'(bus.immediate);
    assign capture_p0 = (state == ST_IDLE) && (bus.stage == STAGE_EX) &&
                        (bus.opcode == STORE_OPCODE);

    // ---- stage p0 -> p1: latch operands once per instruction ----
    // Operand latch; only loads in IDLE so a held execute stage keeps the first sample.
    always_ff @(posedge clk) begin
        if (capture_p0) begin
            ea_p1     <= ea_sum_p0;
            rs2_p1    <= bus.bus_rs2;
            funct3_p1 <= bus.funct3;
        end
    end

    store_lane_align u_align (
        .funct3      (funct3_p1),
        .offset      (ea_p1[1:0]),
        .rs2         (rs2_p1),
        .byte_enable (lane_be_p1),
        .data        (lane_data_p1),
        .legal       (legal_p1)
    );

    // ---- stage p1 -> p2: FSM and registered memory-port outputs ----
    // Store sequencer; pulses default low so each strobe lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            we_p2    <= 1'b0;
            done_p2  <= 1'b0;
            fault_p2 <= 1'b0;
            be_p2    <= 4'b0000;
            addr_p2  <= '0;
            data_p2  <= '0;
        end else begin
            we_p2    <= 1'b0;
            done_p2  <= 1'b0;
            fault_p2 <= 1'b0;
            be_p2    <= 4'b0000;
            case (state)
                ST_IDLE: begin
                    if (capture_p0) begin
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.stage == STAGE_MEM) begin
                        if (legal_p1) begin
                            we_p2   <= 1'b1;
                            done_p2 <= 1'b1;
                            be_p2   <= lane_be_p1;
                            addr_p2 <= {ea_p1[ADDR_WIDTH-1:2], 2'b00};
                            data_p2 <= lane_data_p1;
                            state   <= ST_WRITE;
                        end else begin
                            fault_p2 <= 1'b1;
                            state    <= ST_HOLD;
                        end
                    end else if (bus.stage != STAGE_EX) begin
                        // Pipeline flushed before the memory stage: drop quietly.
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.stage != STAGE_MEM) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dmem_write_enable = we_p2;
    assign bus.dmem_read_enable  = 1'b0;
    assign bus.dmem_address      = addr_p2;
    assign bus.dmem_write_data   = data_p2;
    assign bus.dmem_byte_enable  = be_p2;
    assign bus.store_done        = done_p2;
    assign bus.store_fault       = fault_p2;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed vector table, multi-cycle corner sequences
// and randomized stores against a behavioural model.
module tb_store_unit;
    import store_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    store_unit_if #(.ADDR_WIDTH(32)) bus ();

    store_unit #(.ADDR_WIDTH(32), .STORE_OPCODE(7'b0100011)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] rs2;
        logic [2:0]  f3;
        logic        exp_fault;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural reference: byte i of the written word is byte (i mod size) of rs2.
    task automatic model(input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [31:0] rs2, input logic [2:0] f3,
                         output logic fault, output logic [31:0] addr,
                         output logic [3:0] be, output logic [31:0] data);
        logic [31:0] ea;
        int size;
        int off;
        ea   = rs1 + imm;
        size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        off  = int'(ea % 4);
        addr = ea - (ea % 4);
        be   = 4'b0000;
        data = 32'h0;
        if (size == 0 || (off % size) != 0) begin
            fault = 1'b1;
        end else begin
            fault = 1'b0;
            be    = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) begin
                data = data | (((rs2 >> (8 * (i % size))) & 32'hFF) << (8 * i));
            end
        end
    endtask

    // Drives one store through stage 2 (with optional extra held cycles whose
    // operands must be ignored) then stage 3 for mem_cycles, then stage 0.
    task automatic run_store(input logic [31:0] rs1, input logic [31:0] imm,
                             input logic [31:0] rs2, input logic [2:0] f3,
                             input int extra_ex, input int mem_cycles,
                             output logic pre_we, output logic wr_we, output logic wr_done,
                             output logic wr_fault, output logic [31:0] wr_addr,
                             output logic [31:0] wr_data, output logic [3:0] wr_be,
                             output int we_pulses, output int fault_pulses,
                             output logic [3:0] be_after, output logic [31:0] addr_after);
        bus.stage     = STAGE_EX;
        bus.opcode    = OPC_STORE;
        bus.bus_rs1   = rs1;
        bus.immediate = imm;
        bus.bus_rs2   = rs2;
        bus.funct3    = f3;
        @(posedge clk); #1;
        repeat (extra_ex) begin
            bus.bus_rs1   = $urandom;
            bus.immediate = $urandom;
            bus.bus_rs2   = $urandom;
            bus.funct3    = 3'($urandom);
            @(posedge clk); #1;
        end
        pre_we        = bus.dmem_write_enable | bus.store_fault;
        bus.stage     = STAGE_MEM;
        bus.opcode    = 7'h33;
        bus.bus_rs1   = $urandom;
        bus.bus_rs2   = $urandom;
        @(posedge clk); #1;
        wr_we        = bus.dmem_write_enable;
        wr_done      = bus.store_done;
        wr_fault     = bus.store_fault;
        wr_addr      = bus.dmem_address;
        wr_data      = bus.dmem_write_data;
        wr_be        = bus.dmem_byte_enable;
        we_pulses    = int'(bus.dmem_write_enable);
        fault_pulses = int'(bus.store_fault);
        be_after     = 4'hx;
        addr_after   = 32'hx;
        for (int c = 1; c < mem_cycles; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                be_after   = bus.dmem_byte_enable;
                addr_after = bus.dmem_address;
            end
            we_pulses    += int'(bus.dmem_write_enable);
            fault_pulses += int'(bus.store_fault);
        end
        bus.stage = 2'd0;
        @(posedge clk); #1;
        we_pulses    += int'(bus.dmem_write_enable);
        fault_pulses += int'(bus.store_fault);
    endtask

    task automatic check_store(input string tag, input logic [31:0] rs1, input logic [31:0] imm,
                               input logic [31:0] rs2, input logic [2:0] f3,
                               input logic exp_fault, input logic [31:0] exp_addr,
                               input logic [3:0] exp_be, input logic [31:0] exp_data,
                               input int extra_ex, input int mem_cycles);
        logic pre_we, wr_we, wr_done, wr_fault;
        logic [31:0] wr_addr, wr_data, addr_after;
        logic [3:0] wr_be, be_after;
        int we_pulses, fault_pulses;
        run_store(rs1, imm, rs2, f3, extra_ex, mem_cycles, pre_we, wr_we, wr_done, wr_fault,
                  wr_addr, wr_data, wr_be, we_pulses, fault_pulses, be_after, addr_after);
        chk({tag, "_early"}, 32'(pre_we), 32'd0);
        if (!exp_fault) begin
            chk({tag, "_we"}, 32'(wr_we), 32'd1);
            chk({tag, "_done"}, 32'(wr_done), 32'd1);
            chk({tag, "_fault"}, 32'(wr_fault), 32'd0);
            chk({tag, "_addr"}, wr_addr, exp_addr);
            chk({tag, "_be"}, 32'(wr_be), 32'(exp_be));
            chk({tag, "_data"}, wr_data, exp_data);
            chk({tag, "_we_pulses"}, 32'(we_pulses), 32'd1);
            chk({tag, "_be_cleared"}, 32'(be_after), 32'd0);
            chk({tag, "_addr_held"}, addr_after, exp_addr);
        end else begin
            chk({tag, "_fault"}, 32'(wr_fault), 32'd1);
            chk({tag, "_we"}, 32'(wr_we), 32'd0);
            chk({tag, "_done"}, 32'(wr_done), 32'd0);
            chk({tag, "_fault_pulses"}, 32'(fault_pulses), 32'd1);
            chk({tag, "_we_pulses"}, 32'(we_pulses), 32'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_we"}, 32'(bus.dmem_write_enable), 32'd0);
        chk({tag, "_done"}, 32'(bus.store_done), 32'd0);
        chk({tag, "_fault"}, 32'(bus.store_fault), 32'd0);
        chk({tag, "_be"}, 32'(bus.dmem_byte_enable), 32'd0);
        chk({tag, "_addr"}, bus.dmem_address, 32'd0);
        chk({tag, "_data"}, bus.dmem_write_data, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int faults;
        logic        m_fault;
        logic [31:0] m_addr;
        logic [3:0]  m_be;
        logic [31:0] m_data;
        logic [31:0] r_rs1, r_imm, r_rs2;
        logic [2:0]  r_f3;

        checks = 0;
        errors = 0;

        //               rs1           imm           rs2           f3     flt  addr          be       data
        vecs[0]  = '{32'h0000_0100, 32'h0000_0004, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF};
        vecs[1]  = '{32'h0000_0008, 32'h0000_0000, 32'h0000_0077, 3'b000, 1'b0, 32'h0000_0008, 4'b0001, 32'h7777_7777};
        vecs[2]  = '{32'h0000_0203, 32'h0000_0000, 32'h0000_00A5, 3'b000, 1'b0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5};
        vecs[3]  = '{32'h0000_0101, 32'h0000_0000, 32'h1234_5678, 3'b001, 1'b1, 32'h0,         4'b0000, 32'h0};
        vecs[4]  = '{32'h0000_0102, 32'h0000_0000, 32'h1234_CAFE, 3'b001, 1'b0, 32'h0000_0100, 4'b1100, 32'hCAFE_CAFE};
        vecs[5]  = '{32'hFFFF_FFFC, 32'h0000_0008, 32'h1122_3344, 3'b010, 1'b0, 32'h0000_0004, 4'b1111, 32'h1122_3344};
        vecs[6]  = '{32'h0000_0102, 32'h0000_0000, 32'h1111_1111, 3'b010, 1'b1, 32'h0,         4'b0000, 32'h0};
        vecs[7]  = '{32'h0000_0100, 32'h0000_0000, 32'h2222_2222, 3'b011, 1'b1, 32'h0,         4'b0000, 32'h0};
        vecs[8]  = '{32'h0000_0100, 32'h0000_0000, 32'h3333_3333, 3'b100, 1'b1, 32'h0,         4'b0000, 32'h0};
        vecs[9]  = '{32'h0000_0200, 32'hFFFF_FFFE, 32'hAAAA_5555, 3'b001, 1'b0, 32'h0000_01FC, 4'b1100, 32'h5555_5555};
        vecs[10] = '{32'h0000_0011, 32'h0000_0000, 32'h0000_003C, 3'b000, 1'b0, 32'h0000_0010, 4'b0010, 32'h3C3C_3C3C};

        rst_n         = 1'b0;
        bus.stage     = 2'd0;
        bus.opcode    = 7'd0;
        bus.funct3    = 3'd0;
        bus.bus_rs1   = 32'd0;
        bus.bus_rs2   = 32'd0;
        bus.immediate = 32'd0;
        @(posedge clk); #1;
        check_idle_outputs("reset");
        chk("reset_read_enable", 32'(bus.dmem_read_enable), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table; entry 0 holds stage 3 for six cycles so a single pulse is required.
        for (int i = 0; i < 11; i++) begin
            check_store($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].imm, vecs[i].rs2, vecs[i].f3,
                        vecs[i].exp_fault, vecs[i].exp_addr, vecs[i].exp_be, vecs[i].exp_data,
                        (i == 4) ? 2 : 0, (i == 0) ? 6 : 2);
        end

        // Abort: latch in stage 2, jump to stage 0, then a stage 3 without a new stage 2.
        bus.stage   = STAGE_EX;
        bus.opcode  = OPC_STORE;
        bus.funct3  = F3_SW;
        bus.bus_rs1 = 32'h40;
        @(posedge clk); #1;
        bus.stage = 2'd0;
        pulses = 0;
        faults = 0;
        @(posedge clk); #1;
        pulses += int'(bus.dmem_write_enable);
        faults += int'(bus.store_fault);
        bus.opcode = 7'h33;
        bus.stage  = STAGE_MEM;
        repeat (3) begin
            @(posedge clk); #1;
            pulses += int'(bus.dmem_write_enable);
            faults += int'(bus.store_fault);
        end
        chk("abort_we_pulses", 32'(pulses), 32'd0);
        chk("abort_fault_pulses", 32'(faults), 32'd0);
        bus.stage = 2'd0;
        @(posedge clk); #1;

        // Asynchronous reset while the write strobe is high.
        bus.stage     = STAGE_EX;
        bus.opcode    = OPC_STORE;
        bus.funct3    = F3_SW;
        bus.bus_rs1   = 32'h0000_0300;
        bus.immediate = 32'h0000_0004;
        bus.bus_rs2   = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.stage = STAGE_MEM;
        @(posedge clk); #1;
        chk("rst_pre_we", 32'(bus.dmem_write_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        #2 rst_n = 1'b1;
        pulses = 0;
        faults = 0;
        repeat (4) begin
            @(posedge clk); #1;
            pulses += int'(bus.dmem_write_enable);
            faults += int'(bus.store_fault);
        end
        chk("rst_release_we_pulses", 32'(pulses), 32'd0);
        chk("rst_release_fault_pulses", 32'(faults), 32'd0);
        bus.stage = 2'd0;
        @(posedge clk); #1;

        // Randomized stores against the model.
        for (int n = 0; n < 200; n++) begin
            r_rs1 = $urandom;
            r_imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
            r_rs2 = $urandom;
            r_f3  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            model(r_rs1, r_imm, r_rs2, r_f3, m_fault, m_addr, m_be, m_data);
            check_store($sformatf("rnd%0d", n), r_rs1, r_imm, r_rs2, r_f3,
                        m_fault, m_addr, m_be, m_data,
                        int'($urandom_range(0, 2)), int'($urandom_range(2, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
